multi_station_weapons_controller: RTL

//  Parametrised successor of the single-rail weapons control unit. Manages NUM_STATIONS launch stations,

---
 rtl/wcu_pkg.sv | 15 +
 rtl/wcu_rr_arbiter.sv | 37 +++
 rtl/multi_station_weapons_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wcu_pkg.sv
// Shared state codes for the weapons control unit family.
package wcu_pkg;

  localparam int unsigned WCU_STATE_W = 3;

  typedef enum logic [WCU_STATE_W-1:0] {
    WCU_IDLE     = 3'd0,
    WCU_LOCKING  = 3'd1,
    WCU_ARMED    = 3'd2,
    WCU_FIRING   = 3'd3,
    WCU_COOLDOWN = 3'd4,
    WCU_EMPTY    = 3'd5
  } wcu_state_e;

endpackage

// File: rtl/wcu_rr_arbiter.sv
// Combinational round-robin picker: first eligible station at or above ptr, wrapping.
module wcu_rr_arbiter
  import wcu_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_valid
);

  int unsigned     idx;
  logic [PW-1:0]   idx_p;

  // Scan N positions starting at ptr; the first eligible one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_p     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      idx_p = PW'(idx);
      if (!any_valid && eligible[idx_p]) begin
        any_valid        = 1'b1;
        grant[idx_p]     = 1'b1;
        grant_idx        = idx_p;
      end
    end
  end

endmodule

// File: rtl/multi_station_weapons_controller.sv
// Multi-station weapons controller: lock qualification, round-robin salvos with cooldown, reload.
module multi_station_weapons_controller
  import wcu_pkg::*;
#(
  parameter int unsigned NUM_STATIONS         = 4,
  parameter int unsigned MISSILES_PER_STATION = 4,
  parameter int unsigned LOCK_CYCLES          = 2,
  parameter int unsigned COOLDOWN_CYCLES      = 3,
  localparam int unsigned CNT_W = $clog2(NUM_STATIONS * MISSILES_PER_STATION + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    target_locked,
  input  logic                    fire_command,
  input  logic [CNT_W-1:0]        salvo_size,
  input  logic [NUM_STATIONS-1:0] station_enable,
  input  logic                    reload,
  output logic [NUM_STATIONS-1:0] launch_missile,
  output logic [CNT_W-1:0]        remaining_missiles,
  output logic [NUM_STATIONS-1:0] station_empty,
  output logic [WCU_STATE_W-1:0]  WCU_state
);

  localparam int unsigned SW = $clog2(MISSILES_PER_STATION + 1);
  localparam int unsigned PW = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [SW-1:0]    FULL      = SW'(MISSILES_PER_STATION);
  localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(NUM_STATIONS * MISSILES_PER_STATION);

  wcu_state_e                         state;
  logic [NUM_STATIONS-1:0][SW-1:0]    store;
  logic [NUM_STATIONS-1:0][SW-1:0]    store_nxt;
  logic [CNT_W-1:0]                   sum_nxt;
  logic [NUM_STATIONS-1:0]            empty_nxt;
  logic [NUM_STATIONS-1:0]            eligible;
  logic [NUM_STATIONS-1:0]            grant;
  logic [PW-1:0]                      grant_idx;
  logic                               any_valid;
  logic [PW-1:0]                      rr_ptr;
  logic [PW-1:0]                      sel_idx;
  logic [CNT_W-1:0]                   salvo_left;
  logic [LW-1:0]                      lock_cnt;
  logic [CW-1:0]                      cd_cnt;
  logic                               fire_prev;
  logic                               fire_rise;

  assign fire_rise = fire_command & ~fire_prev;
  assign WCU_state = state;

  // A station is a launch candidate only when armed by the pilot and still holding missiles.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < NUM_STATIONS; k++) begin
      eligible[k] = station_enable[k] & (store[k] != '0);
    end
  end

  wcu_rr_arbiter #(.N(NUM_STATIONS)) u_arb (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Next store contents: reload refills unless a launch is in progress, launch decrements.
  always_comb begin
    store_nxt = store;
    if (reload && state != WCU_FIRING) store_nxt = {NUM_STATIONS{FULL}};
    if (state == WCU_FIRING && store[sel_idx] != '0) store_nxt[sel_idx] = store[sel_idx] - SW'(1);
    sum_nxt   = '0;
    empty_nxt = '0;
    for (int unsigned k = 0; k < NUM_STATIONS; k++) begin
      sum_nxt      = sum_nxt + CNT_W'(store_nxt[k]);
      empty_nxt[k] = (store_nxt[k] == '0);
    end
  end

  // Controller FSM with registered stores, totals and launch pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WCU_IDLE;
      store              <= {NUM_STATIONS{FULL}};
      remaining_missiles <= TOTAL;
      station_empty      <= '0;
      launch_missile     <= '0;
      rr_ptr             <= '0;
      sel_idx            <= '0;
      salvo_left         <= '0;
      lock_cnt           <= '0;
      cd_cnt             <= '0;
      fire_prev          <= 1'b0;
    end else begin
      fire_prev          <= fire_command;
      store              <= store_nxt;
      remaining_missiles <= sum_nxt;
      station_empty      <= empty_nxt;
      launch_missile     <= '0;
      case (state)
        WCU_IDLE: begin
          if (remaining_missiles == '0) begin
            state <= WCU_EMPTY;
          end else if (target_locked) begin
            lock_cnt <= LW'(1);
            state    <= (LOCK_CYCLES == 1) ? WCU_ARMED : WCU_LOCKING;
          end
        end
        WCU_LOCKING: begin
          if (!target_locked) begin
            lock_cnt <= '0;
            state    <= WCU_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) state <= WCU_ARMED;
          end
        end
        WCU_ARMED: begin
          if (!target_locked) begin
            state <= WCU_IDLE;
          end else if (fire_rise && any_valid) begin
            salvo_left     <= (salvo_size == '0) ? CNT_W'(1) : salvo_size;
            sel_idx        <= grant_idx;
            launch_missile <= grant;
            state          <= WCU_FIRING;
          end
        end
        WCU_FIRING: begin
          rr_ptr     <= (sel_idx == PW'(NUM_STATIONS - 1)) ? '0 : sel_idx + PW'(1);
          salvo_left <= salvo_left - CNT_W'(1);
          cd_cnt     <= '0;
          state      <= WCU_COOLDOWN;
        end
        WCU_COOLDOWN: begin
          if (cd_cnt != CW'(COOLDOWN_CYCLES - 1)) begin
            cd_cnt <= cd_cnt + CW'(1);
          end else if (remaining_missiles == '0) begin
            state <= WCU_EMPTY;
          end else if (!target_locked) begin
            salvo_left <= '0;
            state      <= WCU_IDLE;
          end else if (salvo_left != '0 && any_valid) begin
            sel_idx        <= grant_idx;
            launch_missile <= grant;
            state          <= WCU_FIRING;
          end else begin
            state <= WCU_ARMED;
          end
        end
        WCU_EMPTY: begin
          if (reload) state <= WCU_IDLE;
        end
        default: state <= WCU_IDLE;
      endcase
    end
  end

endmodule
